stack_frame_ctrl: RTL and testbench

- Call-frame sequencer for the SuperStack operand stack in the wasm execution core.
- Accepts CALL/RETURN commands from the instruction decoder and keeps a private LIFO of saved frame bases.
- Drives the SuperStack op/data/offset/underflow_limit inputs to open a protected frame on CALL.
- On RETURN it unwinds the frame, carrying 0 or 1 result value down to the frame base.
- Owns the stack port only while busy=1; the integrating mux gives the port to the decoder when busy=0.

---
 rtl/stack_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_stack_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_frame_ctrl.sv
// Call-frame sequencer for the SuperStack operand stack: opens protected frames on CALL
// and unwinds them on RETURN, carrying at most one result down to the frame base.

`ifndef NONE
`define NONE 3'd0
`endif
`ifndef INDEX_RESET
`define INDEX_RESET 3'd4
`endif
`ifndef INDEX_RESET_AND_PUSH
`define INDEX_RESET_AND_PUSH 3'd5
`endif
`ifndef UNDERFLOW
`define UNDERFLOW 3'd3
`endif
`ifndef OVERFLOW
`define OVERFLOW 3'd4
`endif
`ifndef BAD_OFFSET
`define BAD_OFFSET 3'd5
`endif

module stack_frame_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned FRAMES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd,
  input  logic [DEPTH:0]             argc,
  input  logic                       retc,
  output logic [2:0]                 st_op,
  output logic [WIDTH-1:0]           st_data,
  output logic [DEPTH:0]             st_offset,
  output logic [DEPTH:0]             st_underflow_limit,
  input  logic [DEPTH:0]             st_index,
  input  logic [WIDTH-1:0]           st_out,
  input  logic [2:0]                 st_status,
  output logic                       busy,
  output logic [$clog2(FRAMES):0]    frame_depth,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int unsigned IW = DEPTH + 1;
  localparam int unsigned AW = $clog2(FRAMES);
  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] E_NOFRAME = 2'd0;
  localparam logic [1:0] E_FULL    = 2'd1;
  localparam logic [1:0] E_ARGS    = 2'd2;
  localparam logic [1:0] E_STACK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_DONE,
    S_RET_ISSUE,
    S_RET_WAIT,
    S_RET_CHECK
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    off_q, off_d;
  logic [IW-1:0]    limit_q, limit_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [IW-1:0]    lifo_q [FRAMES];
  logic             push_en;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [IW-1:0]    avail;
  logic             stack_fault;

  assign avail       = st_index - limit_q;
  assign push_idx    = AW'(depth_q);
  assign pop_idx     = AW'(depth_q - DW'(1));
  assign stack_fault = (st_status == `UNDERFLOW) || (st_status == `OVERFLOW) ||
                       (st_status == `BAD_OFFSET);

  // Next state and next registered outputs; the stack op lives only in RET_ISSUE
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    op_d    = `NONE;
    data_d  = '0;
    off_d   = '0;
    limit_d = limit_q;
    depth_d = depth_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    push_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          if (!cmd) begin
            if (depth_q == DW'(FRAMES)) begin
              err_d  = 1'b1;
              code_d = E_FULL;
            end else if (argc > avail) begin
              err_d  = 1'b1;
              code_d = E_ARGS;
            end else begin
              push_en = 1'b1;
              limit_d = st_index - argc;
              depth_d = depth_q + DW'(1);
              done_d  = 1'b1;
              state_d = S_CALL_DONE;
            end
          end else begin
            if (depth_q == '0) begin
              err_d  = 1'b1;
              code_d = E_NOFRAME;
            end else if (retc && (st_index == limit_q)) begin
              err_d  = 1'b1;
              code_d = E_ARGS;
            end else begin
              busy_d  = 1'b1;
              op_d    = retc ? `INDEX_RESET_AND_PUSH : `INDEX_RESET;
              off_d   = limit_q;
              data_d  = retc ? st_out : '0;
              state_d = S_RET_ISSUE;
            end
          end
        end
      end
      S_CALL_DONE: state_d = S_IDLE;
      S_RET_ISSUE: begin
        busy_d  = 1'b1;
        state_d = S_RET_WAIT;
      end
      S_RET_WAIT: begin
        busy_d  = 1'b1;
        state_d = S_RET_CHECK;
      end
      S_RET_CHECK: begin
        state_d = S_IDLE;
        if (stack_fault) begin
          err_d  = 1'b1;
          code_d = E_STACK;
        end else begin
          limit_d = lifo_q[pop_idx];
          depth_d = depth_q - DW'(1);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      op_q    <= `NONE;
      data_q  <= '0;
      off_q   <= '0;
      limit_q <= '0;
      depth_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      data_q  <= data_d;
      off_q   <= off_d;
      limit_q <= limit_d;
      depth_q <= depth_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Saved caller bases; validity is tracked by depth_q, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_en) lifo_q[push_idx] <= limit_q;
  end

  assign cmd_ready          = ready_q;
  assign busy               = busy_q;
  assign st_op              = op_q;
  assign st_data            = data_q;
  assign st_offset          = off_q;
  assign st_underflow_limit = limit_q;
  assign frame_depth        = depth_q;
  assign done               = done_q;
  assign err                = err_q;
  assign err_code           = code_q;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Bench for stack_frame_ctrl: a small SuperStack model plus a transaction-level
// frame model (queue of saved bases) checked against the DUT every cycle.

`ifndef NONE
`define NONE 3'd0
`endif
`ifndef PUSH
`define PUSH 3'd1
`endif
`ifndef POP
`define POP 3'd2
`endif
`ifndef INDEX_RESET
`define INDEX_RESET 3'd4
`endif
`ifndef INDEX_RESET_AND_PUSH
`define INDEX_RESET_AND_PUSH 3'd5
`endif
`ifndef NORMAL
`define NORMAL 3'd0
`endif
`ifndef UNDERFLOW
`define UNDERFLOW 3'd3
`endif
`ifndef OVERFLOW
`define OVERFLOW 3'd4
`endif
`ifndef BAD_OFFSET
`define BAD_OFFSET 3'd5
`endif

module tb_stack_frame_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned FRAMES = 4;
  localparam int unsigned IW     = DEPTH + 1;
  localparam int unsigned DW     = $clog2(FRAMES) + 1;
  localparam int unsigned CAP    = (1 << IW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid, cmd_ready, cmd, retc;
  logic [IW-1:0]    argc;
  logic [2:0]       st_op;
  logic [WIDTH-1:0] st_data;
  logic [IW-1:0]    st_offset, st_underflow_limit, st_index;
  logic [WIDTH-1:0] st_out;
  logic [2:0]       st_status;
  logic             busy, done, err;
  logic [DW-1:0]    frame_depth;
  logic [1:0]       err_code;

  always #5 clk = ~clk;

  stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .argc(argc), .retc(retc), .st_op(st_op), .st_data(st_data), .st_offset(st_offset),
    .st_underflow_limit(st_underflow_limit), .st_index(st_index), .st_out(st_out),
    .st_status(st_status), .busy(busy), .frame_depth(frame_depth), .done(done), .err(err),
    .err_code(err_code)
  );

  // SuperStack model; port muxed to the controller while busy
  logic [WIDTH-1:0] mem [0:CAP];
  logic [IW-1:0]    sm_idx = '0;
  logic [2:0]       sm_stat = `NORMAL;
  logic             inj_en = 1'b0;
  logic [2:0]       inj_val = 3'd0;
  logic [2:0]       dec_op = `NONE;
  logic [WIDTH-1:0] dec_data = '0;
  logic [2:0]       m_op;
  logic [WIDTH-1:0] m_data;
  logic [IW-1:0]    m_off;

  assign m_op      = busy ? st_op : dec_op;
  assign m_data    = busy ? st_data : dec_data;
  assign m_off     = busy ? st_offset : '0;
  assign st_index  = sm_idx;
  assign st_out    = (sm_idx == '0) ? '0 : mem[sm_idx - IW'(1)];
  assign st_status = inj_en ? inj_val : sm_stat;

  always @(posedge clk) begin
    case (m_op)
      `PUSH:
        if (sm_idx == IW'(CAP)) sm_stat <= `OVERFLOW;
        else begin mem[sm_idx] <= m_data; sm_idx <= sm_idx + IW'(1); sm_stat <= `NORMAL; end
      `POP:
        if (sm_idx == st_underflow_limit) sm_stat <= `UNDERFLOW;
        else begin sm_idx <= sm_idx - IW'(1); sm_stat <= `NORMAL; end
      `INDEX_RESET:
        if (m_off > sm_idx) sm_stat <= `BAD_OFFSET;
        else begin sm_idx <= m_off; sm_stat <= `NORMAL; end
      `INDEX_RESET_AND_PUSH:
        if (m_off > sm_idx) sm_stat <= `BAD_OFFSET;
        else if (m_off == IW'(CAP)) begin sm_idx <= m_off; sm_stat <= `OVERFLOW; end
        else begin mem[m_off] <= m_data; sm_idx <= m_off + IW'(1); sm_stat <= `NORMAL; end
      default: ;
    endcase
  end

  // Frame model: current base plus a queue of saved caller bases
  logic [IW-1:0]    base;
  logic [IW-1:0]    saved [$];
  logic             exp_ready, exp_busy, exp_done, exp_err;
  logic [2:0]       exp_op;
  logic [WIDTH-1:0] exp_data;
  logic [IW-1:0]    exp_off, exp_lim;
  logic [DW-1:0]    exp_depth;
  logic [1:0]       exp_code;
  int               n_chk = 0;
  int               n_pass = 0;
  bit               chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
  endtask

  function automatic void set_idle();
    exp_ready = 1'b1; exp_busy = 1'b0; exp_op = `NONE; exp_data = '0; exp_off = '0;
    exp_lim = base; exp_depth = DW'(saved.size()); exp_done = 1'b0; exp_err = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(exp_busy));
      check("st_op", 32'(st_op), 32'(exp_op));
      check("st_data", 32'(st_data), 32'(exp_data));
      check("st_offset", 32'(st_offset), 32'(exp_off));
      check("limit", 32'(st_underflow_limit), 32'(exp_lim));
      check("frame_depth", 32'(frame_depth), 32'(exp_depth));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(exp_err));
      check("err_code", 32'(err_code), 32'(exp_code));
    end
  end

  task automatic dec(input logic [2:0] op, input logic [WIDTH-1:0] d);
    @(negedge clk);
    dec_op = op; dec_data = d;
    @(posedge clk); #1;
    dec_op = `NONE;
  endtask

  // Presents one command; outcome predicted from the frame rules, then stepped per cycle
  task automatic do_cmd(input logic c, input logic [IW-1:0] a, input logic r,
                        input logic use_inj, input logic [2:0] inj,
                        output int lat, output logic got_err, output logic [2:0] cop,
                        output logic [IW-1:0] coff, output logic [WIDTH-1:0] cdata);
    int kind;
    logic [1:0] code;
    logic [IW-1:0] idx, avail, nb;
    logic [WIDTH-1:0] rv;
    logic [2:0] stat;
    lat = -1; got_err = 1'b0; cop = `NONE; coff = '0; cdata = '0;
    kind = 2; code = 2'd0; nb = '0; stat = `NORMAL;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; argc = a; retc = r; dec_op = `NONE;
    idx = st_index; rv = st_out; avail = idx - base;
    if (!c) begin
      if (saved.size() == FRAMES) code = 2'd1;
      else if (a > avail) code = 2'd2;
      else begin kind = 0; nb = idx - a; end
    end else begin
      if (saved.size() == 0) code = 2'd0;
      else if (r && (idx == base)) code = 2'd2;
      else kind = 1;
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) cmd_valid = 1'b0;
      if (kind == 0) begin
        if (k == 1) begin
          saved.push_back(base); base = nb; set_idle();
          exp_ready = 1'b0; exp_done = 1'b1;
        end else set_idle();
      end else if (kind == 2) begin
        set_idle();
        if (k == 1) begin exp_err = 1'b1; exp_code = code; end
      end else begin
        set_idle();
        if (k <= 3) begin exp_ready = 1'b0; exp_busy = 1'b1; end
        if (k == 1) begin
          exp_op = r ? `INDEX_RESET_AND_PUSH : `INDEX_RESET;
          exp_off = base; exp_data = r ? rv : '0;
        end
        if (k == 2 && use_inj) begin inj_en = 1'b1; inj_val = inj; end
        if (k == 3) stat = st_status;
        if (k == 4) begin
          inj_en = 1'b0;
          if (stat == `UNDERFLOW || stat == `OVERFLOW || stat == `BAD_OFFSET) begin
            exp_err = 1'b1; exp_code = 2'd3;
          end else begin
            base = saved.pop_back(); set_idle(); exp_done = 1'b1;
          end
        end
      end
      if (k == 1) begin cop = st_op; coff = st_offset; cdata = st_data; end
      if (lat < 0 && (done || err)) begin lat = k; got_err = err; end
      if (kind != 1 && k == 2) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic ge;
    logic [2:0] cop;
    logic [IW-1:0] coff;
    logic [WIDTH-1:0] cdata;
    cmd_valid = 1'b0; cmd = 1'b0; argc = '0; retc = 1'b0;
    base = '0; exp_code = 2'd0; set_idle();
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_depth", 32'(frame_depth), 32'd0);
    check("rst_op", 32'(st_op), 32'(`NONE));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // Open a frame over five values with two arguments
    for (int i = 0; i < 5; i++) dec(`PUSH, WIDTH'(8'h10 + i));
    do_cmd(1'b0, IW'(2), 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("call_lat", 32'(lat), 32'd1);
    check("call_limit", 32'(st_underflow_limit), 32'd3);
    check("call_depth", 32'(frame_depth), 32'd1);
    repeat (3) dec(`POP, '0);
    check("pop_underflow", 32'(st_status), 32'(`UNDERFLOW));
    check("pop_index", 32'(st_index), 32'd3);

    // Return one result down to the frame base
    dec(`PUSH, 8'h11); dec(`PUSH, 8'h12); dec(`PUSH, 8'h2A);
    check("pre_ret_index", 32'(st_index), 32'd6);
    do_cmd(1'b1, '0, 1'b1, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("ret1_op", 32'(cop), 32'(`INDEX_RESET_AND_PUSH));
    check("ret1_off", 32'(coff), 32'd3);
    check("ret1_data", 32'(cdata), 32'h2A);
    check("ret1_lat", 32'(lat), 32'd4);
    check("ret1_index", 32'(st_index), 32'd4);
    check("ret1_top", 32'(st_out), 32'h2A);
    check("ret1_limit", 32'(st_underflow_limit), 32'd0);
    check("ret1_depth", 32'(frame_depth), 32'd0);

    // Zero-argument call, zero-result return
    dec(`POP, '0); dec(`POP, '0);
    do_cmd(1'b0, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("call0_limit", 32'(st_underflow_limit), 32'd2);
    do_cmd(1'b1, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("ret0_op", 32'(cop), 32'(`INDEX_RESET));
    check("ret0_off", 32'(coff), 32'd2);
    check("ret0_done", 32'(lat), 32'd4);
    check("ret0_index", 32'(st_index), 32'd2);
    check("ret0_limit", 32'(st_underflow_limit), 32'd0);

    // Rejected commands
    do_cmd(1'b1, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("noframe_err", 32'(ge), 32'd1);
    check("noframe_code", 32'(err_code), 32'd0);
    do_cmd(1'b0, IW'(3), 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("args_err", 32'(ge), 32'd1);
    check("args_code", 32'(err_code), 32'd2);
    check("args_limit", 32'(st_underflow_limit), 32'd0);
    check("args_depth", 32'(frame_depth), 32'd0);

    // Fill the base LIFO, overflow it, then unwind
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
      check("fill_ok", 32'(ge), 32'd0);
    end
    do_cmd(1'b0, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    check("full_err", 32'(ge), 32'd1);
    check("full_code", 32'(err_code), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      do_cmd(1'b1, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
      check("unwind_done", 32'(lat), 32'd4);
      check("unwind_depth", 32'(frame_depth), 32'(i));
    end

    // Reset while the return waits on stack status
    do_cmd(1'b0, '0, 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
    @(negedge clk); cmd_valid = 1'b1; cmd = 1'b1; retc = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    set_idle(); exp_ready = 1'b0; exp_busy = 1'b1; exp_op = `INDEX_RESET; exp_off = base;
    @(posedge clk); #1;
    set_idle(); exp_ready = 1'b0; exp_busy = 1'b1;
    #2; chk_en = 1'b0; reset = 1'b0; #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_op", 32'(st_op), 32'(`NONE));
    check("rstmid_depth", 32'(frame_depth), 32'd0);
    check("rstmid_limit", 32'(st_underflow_limit), 32'd0);
    saved.delete(); base = '0; exp_code = 2'd0; set_idle();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // Random mix of decoder traffic, calls and returns with occasional forced status
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 3) begin
        case ($urandom_range(0, 2))
          0: dec(`PUSH, WIDTH'($urandom));
          1: dec(`POP, '0);
          default: dec(`NONE, '0);
        endcase
      end else if (sel <= 6) begin
        do_cmd(1'b0, IW'($urandom_range(0, 4)), 1'b0, 1'b0, 3'd0, lat, ge, cop, coff, cdata);
      end else begin
        do_cmd(1'b1, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               3'($urandom_range(0, 7)), lat, ge, cop, coff, cdata);
      end
    end

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
